// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-word memory port among PORTS requesters
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   addr, din          packed per-requester address / write data (port i at [i*W +: W])
//   re, we             per-requester read / write request (both high means write)
//   dout               data of the most recent completed read, shared by all ports
//   ready              one-cycle completion pulse, one bit per requester
//   maddr, mout        downstream address / write data, held from ISSUE through DONE
//   min, mready        downstream read data / completion
//   mre, mwe           downstream read / write strobe, high for the single ISSUE cycle
//
// Build option: MEM_ARBITER_FIXED_PRIORITY_EN selects lowest-index-wins grant and
// removes the round-robin pointer.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int PORTS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [PORTS*WORD_WIDTH-1:0] din,
    input  logic [PORTS-1:0]            re,
    input  logic [PORTS-1:0]            we,
    output logic [WORD_WIDTH-1:0]       dout,
    output logic [PORTS-1:0]            ready,
    output logic [ADDR_WIDTH-1:0]       maddr,
    output logic [WORD_WIDTH-1:0]       mout,
    input  logic [WORD_WIDTH-1:0]       min,
    output logic                        mre,
    output logic                        mwe,
    input  logic                        mready
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           g_q, g_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0]   mout_q, mout_d;
    logic [WORD_WIDTH-1:0]   dout_q, dout_d;
    logic [PORTS-1:0]        ready_q, ready_d;
    logic                    mre_q, mre_d;
    logic                    mwe_q, mwe_d;

    logic [PORTS-1:0]        req;
    logic [PW-1:0]           grant;

    assign req = re | we;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    // Scan downward so the lowest requesting index is the last assignment.
    always_comb begin
        grant = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (req[PW'(k)]) grant = PW'(k);
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    int            sum;

    // Scan offsets downward from the pointer so the nearest requester at or
    // after ptr (with wrap) is the last assignment and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        sum   = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            sum = int'(ptr_q) + k;
            if (sum >= PORTS) sum = sum - PORTS;
            idx = PW'(sum);
            if (req[idx]) grant = idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_DONE) begin
            ptr_d = (g_q == PW'(PORTS - 1)) ? '0 : g_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        wr_d    = wr_q;
        maddr_d = maddr_q;
        mout_d  = mout_q;
        dout_d  = dout_q;
        ready_d = '0;
        mre_d   = 1'b0;
        mwe_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    g_d     = grant;
                    wr_d    = we[grant];
                    maddr_d = ADDR_WIDTH'(addr >> (grant * ADDR_WIDTH));
                    mout_d  = WORD_WIDTH'(din >> (grant * WORD_WIDTH));
                    // Strobes are registered, so they are set on the way into ISSUE.
                    mre_d   = ~we[grant];
                    mwe_d   = we[grant];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mready) begin
                    if (!wr_q) dout_d = min;
                    ready_d[g_q] = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            wr_q    <= 1'b0;
            maddr_q <= '0;
            mout_q  <= '0;
            dout_q  <= '0;
            ready_q <= '0;
            mre_q   <= 1'b0;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            maddr_q <= maddr_d;
            mout_q  <= mout_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            mre_q   <= mre_d;
            mwe_q   <= mwe_d;
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign maddr = maddr_q;
    assign mout  = mout_q;
    assign mre   = mre_q;
    assign mwe   = mwe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int WW = 16;
    localparam int NP = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NP*AW-1:0] addr;
    logic [NP*WW-1:0] din;
    logic [NP-1:0]    re;
    logic [NP-1:0]    we;
    logic [WW-1:0]    dout;
    logic [NP-1:0]    ready;
    logic [AW-1:0]    maddr;
    logic [WW-1:0]    mout;
    logic [WW-1:0]    min;
    logic             mre;
    logic             mwe;
    logic             mready;

    int            vectors     = 0;
    int            miscompares = 0;
    int            mdl_ptr     = 0;
    logic [WW-1:0] mdl_dout    = '0;

    typedef struct {
        int            port;
        logic          wr;
        logic [AW-1:0] maddr;
        logic [WW-1:0] mout;
        logic [WW-1:0] dout;
    } exp_t;

    typedef struct {
        logic [NP-1:0]    re;
        logic [NP-1:0]    we;
        logic [NP*AW-1:0] addr;
        logic [NP*WW-1:0] din;
        int               delay;
        logic [WW-1:0]    rdata;
        int               exp_port;
    } vec_t;

    exp_t sb[$];
    int   order[$];
    vec_t vt[6];
    int   exp_wrap[3];
    int   exp_fair[6];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORTS(NP)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .re(re), .we(we),
        .dout(dout), .ready(ready), .maddr(maddr), .mout(mout), .min(min),
        .mre(mre), .mwe(mwe), .mready(mready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] m, input int p);
        logic [NP-1:0] r;
        r = m;
        if (p < 0) return -1;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        for (int i = 0; i < NP; i++) if (r[0]) return i; else r = r >> 1;
`else
        for (int i = 0; i < NP; i++) begin
            int j;
            j = (p + i) % NP;
            if (((m >> j) & 1) != 0) return j;
        end
`endif
        return -1;
    endfunction

    task automatic push_exp(input int p, input logic [WW-1:0] rdata);
        exp_t e;
        e.port  = p;
        e.wr    = ((we >> p) & 1) != 0;
        e.maddr = AW'(addr >> (AW * p));
        e.mout  = WW'(din >> (WW * p));
        if (!e.wr) mdl_dout = rdata;
        e.dout  = mdl_dout;
        sb.push_back(e);
    endtask

    // Runs one granted transaction: finds ISSUE, answers after `delay` WAIT
    // cycles, checks DONE, drops the request and optionally re-raises it in IDLE.
    task automatic service(input int delay, input logic [WW-1:0] rdata, input bit reissue);
        exp_t e;
        bit   seen;
        logic sre, swe;
        int   act;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e    = sb.pop_front();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            seen = mre | mwe;
        end
        chk("issue_strobe_seen", seen, 1);
        chk("maddr", maddr, e.maddr);
        chk("mwe", mwe, e.wr);
        chk("mre", mre, !e.wr);
        if (e.wr) chk("mout", mout, e.mout);
        chk("ready_in_issue", ready, 0);
        for (int i = 1; i <= delay; i++) begin
            step();
            chk("wait_strobes", {mre, mwe}, 0);
            if (i == delay) begin
                mready = 1'b1;
                min    = rdata;
            end
        end
        step();
        mready = 1'b0;
        chk("ready_pulse", ready, 64'(4'b0001 << e.port));
        chk("dout", dout, e.dout);
        act = -1;
        for (int i = NP - 1; i >= 0; i--) if (((ready >> i) & 1) != 0) act = i;
        order.push_back(act);
        sre = re[e.port];
        swe = we[e.port];
        re[e.port] = 1'b0;
        we[e.port] = 1'b0;
        mdl_ptr = (e.port + 1) % NP;
        step();
        chk("ready_after_done", ready, 0);
        if (reissue) begin
            re[e.port] = sre;
            we[e.port] = swe;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        re = '0; we = '0; addr = '0; din = '0; mready = 1'b0; min = '0;

        vt[0] = '{4'b0100, 4'b0000, 64'h0000_0040_0000_0000, 64'h0, 3, 16'hDEAD, 2};
        vt[1] = '{4'b0001, 4'b0001, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_1234, 1, 16'hBEEF, 0};
        vt[2] = '{4'b0000, 4'b1000, 64'h0077_0000_0000_0000, 64'h5555_0000_0000_0000, 2, 16'h0BAD, 3};
        vt[3] = '{4'b0010, 4'b0000, 64'h0000_0000_0022_0000, 64'h0000_0000_9999_0000, 1, 16'h0C0C, 1};
        vt[4] = '{4'b1000, 4'b0000, 64'hFFFF_0000_0000_0000, 64'h0, 5, 16'hFFFF, 3};
        vt[5] = '{4'b0110, 4'b0000, 64'h0000_0202_0101_0000, 64'h0, 1, 16'h1111, 1};
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        exp_wrap = '{1, 3, 1};
        exp_fair = '{0, 0, 0, 0, 0, 0};
`else
        exp_wrap = '{3, 1, 2};
        exp_fair = '{0, 1, 2, 3, 0, 1};
`endif

        step();
        step();
        chk("reset_dout", dout, 0);
        chk("reset_ready", ready, 0);
        chk("reset_maddr", maddr, 0);
        chk("reset_mout", mout, 0);
        chk("reset_strobes", {mre, mwe}, 0);
        rst = 1'b1;
        step();

        foreach (vt[i]) begin
            re = vt[i].re; we = vt[i].we; addr = vt[i].addr; din = vt[i].din;
            push_exp(vt[i].exp_port, vt[i].rdata);
            service(vt[i].delay, vt[i].rdata, 1'b0);
            re = '0; we = '0;
        end

        // mready high while idle must be ignored
        mready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_mready_strobes", {mre, mwe}, 0);
            chk("idle_mready_ready", ready, 0);
        end
        mready = 1'b0;

        addr = 64'h3300_2200_1100_0A00;
        din  = 64'hD3D3_D2D2_D1D1_D0D0;

        // bring ptr to 3, then ports 1 and 3 contend, then ports 1 and 2
        re = 4'b0100;
        push_exp(pick(re | we, mdl_ptr), 16'h0202);
        service(1, 16'h0202, 1'b0);
        re = 4'b1010;
        order.delete();
        for (int k = 0; k < 2; k++) begin
            push_exp(pick(re | we, mdl_ptr), WW'(16'h3000 + k));
            service(k + 1, WW'(16'h3000 + k), 1'b0);
        end
        re = 4'b0110;
        push_exp(pick(re | we, mdl_ptr), 16'h3100);
        service(2, 16'h3100, 1'b0);
        re = '0;
        for (int k = 0; k < 3; k++) chk($sformatf("wrap_order_%0d", k), 64'(order[k]), 64'(exp_wrap[k]));

        // reset asserted while in WAIT
        re   = 4'b0001;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            seen = mre;
        end
        chk("rst_issue_seen", seen, 1);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_dout", dout, 0);
        chk("rst_mid_maddr", maddr, 0);
        chk("rst_mid_mout", mout, 0);
        chk("rst_mid_strobes_ready", {mre, mwe, ready}, 0);
        re = '0;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ready", ready, 0);
        end
        mdl_ptr  = 0;
        mdl_dout = '0;

        // all four ports request continuously from ptr 0
        re = 4'b1111;
        order.delete();
        for (int k = 0; k < 6; k++) begin
            push_exp(pick(re | we, mdl_ptr), WW'(16'hA000 + k));
            service(1 + k % 3, WW'(16'hA000 + k), 1'b1);
        end
        re = '0;
        step();
        step();
        for (int k = 0; k < 6; k++) chk($sformatf("fair_order_%0d", k), 64'(order[k]), 64'(exp_fair[k]));

        // mready stuck high: minimum four-cycle occupancy
        mready = 1'b1;
        min    = 16'h7777;
        re     = 4'b0010;
        step();
        chk("stuck_issue_mre", mre, 1);
        step();
        chk("stuck_wait_strobes", {mre, mwe, ready}, 0);
        step();
        chk("stuck_done_ready", ready, 4'b0010);
        chk("stuck_done_dout", dout, 16'h7777);
        re = '0;
        step();
        chk("stuck_idle_ready", ready, 0);
        mready = 1'b0;
        step();
        chk("stuck_no_regrant", {mre, mwe}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one memory port (a cache's upstream `addr`/`din`/`dout`/`re`/`we` interface, or main memory directly) among `PORTS` requesters. Each requester issues single-word reads or writes. The arbiter grants one requester at a time, runs the transaction to completion on the shared port, and returns a one-cycle completion pulse. It sits between processor-side request sources and the cache or memory it feeds.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, address width in bits.
- `WORD_WIDTH`, 64, data word width in bits.
- `PORTS`, 4, number of requesters; legal range ≥2.

Ports. One clock; reset is asynchronous and active-low. The ports are named `clk` and `rst`; `rst` low resets the block.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `addr`  in  `PORTS*ADDR_WIDTH`  packed request addresses; port i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `din`  in  `PORTS*WORD_WIDTH`  packed write data, same slicing as `addr`.
- `re`  in  `PORTS`  read request, one bit per port.
- `we`  in  `PORTS`  write request, one bit per port.
- `dout`  out  `WORD_WIDTH`  last read data, shared by all ports.
- `ready`  out  `PORTS`  one-cycle completion pulse per port.
- `maddr`  out  `ADDR_WIDTH`  downstream address.
- `mout`  out  `WORD_WIDTH`  downstream write data.
- `min`  in  `WORD_WIDTH`  downstream read data.
- `mre`  out  1  downstream read strobe.
- `mwe`  out  1  downstream write strobe.
- `mready`  in  1  downstream completion.

## Operation
Requester protocol:
- A requester raises `re[i]` or `we[i]` and holds it, with `addr`/`din` stable, until it samples `ready[i]`=1.
- It drops the request in the cycle after `ready[i]`.
- If `re[i]` and `we[i]` are both high, the request is a write.

The state machine has four states:
- IDLE: if any request is present, select the grant `g`, register `maddr`←`addr[g]` and `mout`←`din[g]`, latch the operation type, and go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive `mre` or `mwe` high for exactly this one cycle, then go to WAIT.
- WAIT: sample `mready` every cycle.
  - On `mready`=1 for a read, capture `dout`←`min`.
  - On `mready`=1, go to DONE.
  - While in WAIT, `mre`/`mwe` are low.
- DONE: drive `ready[g]`=1 and all other `ready` bits 0, update the pointer, then go to IDLE.

Grant selection:
- Round-robin pointer `ptr`, width `$clog2(PORTS)`, reset value 0.
- `g` is the first requesting index at or after `ptr`, searching upward and wrapping from `PORTS-1` to 0.
- In DONE, `ptr` ← `g+1`, wrapping to 0 when `g+1`=`PORTS`.

Signal timing rules:
- `maddr`/`mout` are held stable from ISSUE through DONE.
- Requests arriving outside IDLE are not sampled until the next IDLE.
- `mready` is ignored in IDLE, ISSUE and DONE.
- `dout` holds its value until the next read completes; writes do not change it.

## Timing
- Reset values: `dout`=0, `ready`=0, `maddr`=0, `mout`=0, `mre`=0, `mwe`=0, `ptr`=0, state IDLE. All outputs are registered.
- A request first visible in IDLE at cycle t produces: `mre`/`mwe` high in cycle t+1, WAIT from t+2.
- If `mready` is first seen high in cycle k (k ≥ t+2), `ready[g]` and the new `dout` appear in cycle k+1, and the block is back in IDLE at k+2.
- Minimum occupancy is 4 cycles per transaction, with `mready` already high on entry to WAIT.
- Back-to-back requests from the same port are not regranted inside DONE. The IDLE after DONE sees that port's request already dropped.
- If reset is asserted mid-transaction, all registers return to reset values immediately. The downstream transaction is abandoned, no `ready` pulse is emitted, and the downstream must also be reset.
- If `mready` is stuck high, ISSUE→WAIT→DONE proceeds at minimum latency; there is no hang.
- `mready` never asserting leaves the block in WAIT indefinitely; there is no timeout.

## Configuration
- `MEM_ARBITER_FIXED_PRIORITY_EN`:
  - When defined, grant is fixed priority: the lowest requesting index always wins, and the `ptr` register and its update logic are compiled out.
  - When undefined, round-robin as described above.
  - All other timing is identical in both builds.

## Test plan
- Single read: port 2 `re` with `addr`=0x40, downstream returns `min`=0xDEAD with `mready` 3 cycles after `mre` → `maddr`=0x40, `mre` high one cycle, `ready`=4'b0100 for one cycle, `dout`=0xDEAD.
- Write precedence: port 0 has `re`=`we`=1 with `din`=0x1234 → `mwe`=1, `mre`=0, `mout`=0x1234, `dout` unchanged.
- Round-robin fairness: all 4 ports request continuously and reissue right after `ready`, starting from `ptr`=0 → completion order 0,1,2,3,0,1; with the macro defined, port 0 every time.
- Wrap: `ptr`=3 and ports 1 and 3 request → port 3 first, then port 1; `ptr` ends at 2.
- Reset mid-WAIT: assert `rst` low while in WAIT → all outputs 0 immediately, no `ready` pulse; after release, a new request completes normally starting from `ptr`=0.
- `mready` high in IDLE with no request → no state change, `mre`=`mwe`=0, `ready`=0.
